// File: rtl/btn_pkg.sv
// Shared definitions for the debounced pushbutton reader: FSM states,
// counter widths and default cycle counts for a 100 MHz board clock.
package btn_pkg;

  // Width of the stability and hold counters
  localparam int CNT_W = 32;

  // Width of the wrapping press counter
  localparam int PRESS_CNT_W = 8;

  // Board clock frequency the default timings are derived from
  localparam int CLK_HZ = 100_000_000;

  // 10 ms of stable input before a new level is accepted
  localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;

  // 1 s of continuous hold before a long press is flagged
  localparam int DEFAULT_LONG_CYCLES = CLK_HZ;

  // Debounce FSM states; LONG_HELD is only reachable when long-press support is built
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PRESS_CHK   = 3'd1,
    HELD        = 3'd2,
    LONG_HELD   = 3'd3,
    RELEASE_CHK = 3'd4
  } btn_state_t;

  // Terminal counter value for a cycle count: a run of N cycles ends at N-1
  function automatic logic [CNT_W-1:0] last_count(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous board inputs.
// The reset value is a parameter so the flops can power up in the
// inactive state of whatever signal they carry.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; second flop gives it a full cycle to settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Debounced pushbutton reader. Synchronizes a raw mechanical button,
// filters contact bounce with a stability counter and produces a clean
// level, one-cycle press/release pulses, a long-press pulse and a
// wrapping press count.
//
// Optional feature macro: LONG_PRESS_EN. When undefined, the hold
// counter, long flag and LONG_HELD state are not built and long_press
// is tied low.
//
// The release pulse port is named release_pulse because "release" is a
// reserved word in SystemVerilog.
module button_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   btn_raw,
  output logic                   btn_level,
  output logic                   press,
  output logic                   release_pulse,
  output logic                   long_press,
  output logic [PRESS_CNT_W-1:0] press_count
);

  // Both cycle counts must describe at least one cycle
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_debounce: DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("button_debounce: LONG_CYCLES must be >= 1");
  end

  localparam logic [CNT_W-1:0] DEB_LAST = last_count(DEBOUNCE_CYCLES);

  logic             pin_pressed;
  logic             s;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  btn_state_t       state;
  btn_state_t       state_n;
  logic             do_press;
  logic             do_release;

`ifdef LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = last_count(LONG_CYCLES);

  logic [CNT_W-1:0] hold;
  logic             hold_run;
  logic             long_flag;
  logic             do_long;
`endif

  // Normalize polarity so 1 always means pressed before the synchronizer
  assign pin_pressed = ACTIVE_LOW ? ~btn_raw : btn_raw;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pin_pressed),
    .q     (s)
  );

  // A new level is accepted once s has disagreed with the committed level long enough
  assign accept = (s != btn_level) && (cnt >= DEB_LAST);

  // Stability counter: runs while s disagrees with the committed level, restarts on any agreement or level change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if ((s == btn_level) || do_press || do_release) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and event decode; a long press wins over starting a release check in the same cycle
  always_comb begin
    state_n    = state;
    do_press   = 1'b0;
    do_release = 1'b0;
`ifdef LONG_PRESS_EN
    do_long    = 1'b0;
    hold_run   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (s) begin
          if (accept) begin
            do_press = 1'b1;
            state_n  = HELD;
          end else begin
            state_n = PRESS_CHK;
          end
        end
      end
      PRESS_CHK: begin
        if (!s) begin
          state_n = IDLE;
        end else if (accept) begin
          do_press = 1'b1;
          state_n  = HELD;
        end
      end
      HELD: begin
`ifdef LONG_PRESS_EN
        if (hold >= LONG_LAST) begin
          do_long = 1'b1;
          state_n = LONG_HELD;
        end else begin
          hold_run = 1'b1;
          if (!s) begin
            if (accept) begin
              do_release = 1'b1;
              state_n    = IDLE;
            end else begin
              state_n = RELEASE_CHK;
            end
          end
        end
`else
        if (!s) begin
          if (accept) begin
            do_release = 1'b1;
            state_n    = IDLE;
          end else begin
            state_n = RELEASE_CHK;
          end
        end
`endif
      end
`ifdef LONG_PRESS_EN
      LONG_HELD: begin
        if (!s) begin
          if (accept) begin
            do_release = 1'b1;
            state_n    = IDLE;
          end else begin
            state_n = RELEASE_CHK;
          end
        end
      end
`endif
      RELEASE_CHK: begin
        if (s) begin
`ifdef LONG_PRESS_EN
          state_n = long_flag ? LONG_HELD : HELD;
`else
          state_n = HELD;
`endif
        end else if (accept) begin
          do_release = 1'b1;
          state_n    = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Committed level and the one-cycle press/release pulses, all registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level     <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= do_press;
      release_pulse <= do_release;
      if (do_press) begin
        btn_level <= 1'b1;
      end else if (do_release) begin
        btn_level <= 1'b0;
      end
    end
  end

  // Press counter wraps naturally at its width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_count <= '0;
    end else if (do_press) begin
      press_count <= press_count + PRESS_CNT_W'(1);
    end
  end

`ifdef LONG_PRESS_EN
  // Hold counter restarts on each press and pauses while a release is being checked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (do_press) begin
      hold <= '0;
    end else if (hold_run) begin
      hold <= hold + CNT_W'(1);
    end
  end

  // Long flag remembers that this press already fired, so a glitch back to HELD cannot fire again
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_flag  <= 1'b0;
      long_press <= 1'b0;
    end else begin
      long_press <= do_long;
      if (do_press) begin
        long_flag <= 1'b0;
      end else if (do_long) begin
        long_flag <= 1'b1;
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce. Two instances run side by
// side: one active-high, one active-low fed the inverted pin, both
// checked every cycle against a window-based reference model.
module tb_button_debounce;

  localparam int DEB  = 4;
  localparam int LONG = 20;
`ifdef LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       btn_raw;
  logic       btn_raw_n;
  logic       lvl0, prs0, rel0, lng0;
  logic       lvl1, prs1, rel1, lng1;
  logic [7:0] cnt0, cnt1;

  int checks   = 0;
  int failures = 0;

  // Model state: pin delay line, recent synchronized samples, committed level
  bit   m1, m2, lastS, prevS;
  bit   sWin[$];
  bit   mLevel, mLongDone;
  int   mHeld;
  logic [7:0] mCount;
  bit   ePress, eRel, eLong;

  // Per-call observations from the active-high instance
  int firstPress, firstRelease, firstLong, numLong;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG),
    .ACTIVE_LOW      (1'b0)
  ) dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_raw       (btn_raw),
    .btn_level     (lvl0),
    .press         (prs0),
    .release_pulse (rel0),
    .long_press    (lng0),
    .press_count   (cnt0)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG),
    .ACTIVE_LOW      (1'b1)
  ) dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_raw       (btn_raw_n),
    .btn_level     (lvl1),
    .press         (prs1),
    .release_pulse (rel1),
    .long_press    (lng1),
    .press_count   (cnt1)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Clear the model to its post-reset picture
  task automatic modelReset();
    m1 = 1'b0; m2 = 1'b0; lastS = 1'b0; prevS = 1'b0;
    sWin.delete();
    for (int i = 0; i < DEB; i++) sWin.push_back(1'b0);
    mLevel = 1'b0; mLongDone = 1'b0; mHeld = 0; mCount = 8'd0;
    ePress = 1'b0; eRel = 1'b0; eLong = 1'b0;
  endtask

  // One clock edge of the model: a level flips when the last DEB samples all disagree with it;
  // a long press is the LONG-th cycle spent held, where a cycle is held if the previous sample was pressed
  task automatic modelStep(input bit p);
    bit sIn, allDiff;
    sIn = m2; m2 = m1; m1 = p;
    prevS = lastS; lastS = sIn;
    sWin.push_back(sIn);
    if (sWin.size() > DEB) void'(sWin.pop_front());
    ePress = 1'b0; eRel = 1'b0; eLong = 1'b0;
    allDiff = 1'b1;
    foreach (sWin[i]) if (sWin[i] == mLevel) allDiff = 1'b0;
    if (mLevel) begin
      if (LONG_EN && !mLongDone && prevS) begin
        if (mHeld == LONG - 1) begin
          eLong = 1'b1; mLongDone = 1'b1;
        end else begin
          mHeld++;
        end
      end
      if (!eLong && allDiff) begin
        eRel = 1'b1; mLevel = 1'b0;
      end
    end else if (allDiff) begin
      ePress = 1'b1; mLevel = 1'b1; mCount = mCount + 8'd1;
      mHeld = 0; mLongDone = 1'b0;
    end
  endtask

  // Hold the pin at pressed value p for n cycles, checking both instances each cycle
  task automatic applyStimulus(input bit p, input int n, input string tag);
    logic [31:0] expV;
    firstPress = 0; firstRelease = 0; firstLong = 0; numLong = 0;
    for (int i = 1; i <= n; i++) begin
      btn_raw   = p;
      btn_raw_n = ~p;
      @(posedge clk);
      #1;
      modelStep(p);
      expV = {20'd0, mLevel, ePress, eRel, eLong, mCount};
      checkOutput({tag, "_hi"}, {20'd0, lvl0, prs0, rel0, lng0, cnt0}, expV);
      checkOutput({tag, "_lo"}, {20'd0, lvl1, prs1, rel1, lng1, cnt1}, expV);
      if (prs0 && firstPress == 0) firstPress = i;
      if (rel0 && firstRelease == 0) firstRelease = i;
      if (lng0 && firstLong == 0) firstLong = i;
      if (lng0) numLong++;
    end
  endtask

  // Assert reset asynchronously, check outputs clear at once, then release on a falling edge
  task automatic doReset(input string tag);
    rst_n = 1'b0;
    #1;
    checkOutput({tag, "_rst_hi"}, {20'd0, lvl0, prs0, rel0, lng0, cnt0}, 32'd0);
    checkOutput({tag, "_rst_lo"}, {20'd0, lvl1, prs1, rel1, lng1, cnt1}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    rst_n     = 1'b1;
    btn_raw   = 1'b0;
    btn_raw_n = 1'b1;
    modelReset();
    #2;
    doReset("init");

    // Clean press and release
    applyStimulus(1'b0, 3, "idle");
    applyStimulus(1'b1, 10, "clean_press");
    checkOutput("clean_press_latency", firstPress, 6);
    checkOutput("clean_press_count", {24'd0, cnt0}, 32'd1);
    applyStimulus(1'b0, 10, "clean_release");
    checkOutput("clean_release_latency", firstRelease, 6);

    // Bounce before settling high
    doReset("bounce");
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 2, "bounce_hi");
      applyStimulus(1'b0, 2, "bounce_lo");
    end
    applyStimulus(1'b1, 10, "bounce_settle");
    checkOutput("bounce_press_latency", firstPress, 6);
    checkOutput("bounce_count", {24'd0, cnt0}, 32'd1);

    // Long press then release
    doReset("long");
    applyStimulus(1'b1, 40, "long_hold");
    checkOutput("long_press_latency", firstPress, 6);
    checkOutput("long_pulse_cycle", firstLong, LONG_EN ? 26 : 0);
    checkOutput("long_pulse_count", numLong, LONG_EN ? 1 : 0);
    applyStimulus(1'b0, 10, "long_release");
    checkOutput("long_release_latency", firstRelease, 6);
    checkOutput("long_no_second", numLong, 0);

    // Short glitch while held: no release, hold count resumes after a 2-cycle pause
    doReset("glitch");
    applyStimulus(1'b1, 10, "glitch_press");
    applyStimulus(1'b0, 2, "glitch_drop");
    applyStimulus(1'b1, 30, "glitch_resume");
    checkOutput("glitch_no_release", firstRelease, 0);
    checkOutput("glitch_level", {31'd0, lvl0}, 32'd1);
    checkOutput("glitch_long_cycle", firstLong, LONG_EN ? 16 : 0);

    // 256 presses wrap the counter back to zero
    doReset("wrap");
    for (int k = 0; k < 256; k++) begin
      applyStimulus(1'b1, 8, "wrap_hi");
      applyStimulus(1'b0, 8, "wrap_lo");
    end
    checkOutput("wrap_count", {24'd0, cnt0}, 32'd0);

    // Reset while pressed, then the still-pressed pin is accepted afresh
    applyStimulus(1'b1, 10, "pre_reset");
    doReset("mid");
    applyStimulus(1'b1, 10, "post_reset");
    checkOutput("post_reset_latency", firstPress, 6);
    checkOutput("post_reset_count", {24'd0, cnt0}, 32'd1);

    // Randomized pin activity with run lengths around the debounce window
    for (int k = 0; k < 200; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(1, 12), "random");
    end
    applyStimulus(1'b1, 30, "random_tail_hi");
    applyStimulus(1'b0, 10, "random_tail_lo");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Debounced pushbutton reader for board-level inputs: the input-side counterpart to the LED drivers, using the same free-running 100 MHz cycle-counting scheme. Synchronizes a raw mechanical button and filters contact bounce with a stability counter. Produces a clean level, one-cycle press/release pulses, a long-press pulse and a wrapping press count. Sits between the board pin and any control logic that consumes user input.

## Interface
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level (10 ms at 100 MHz); legal range ≥ 1
- LONG_CYCLES, 100000000, debounced-held cycles before a long press is flagged (1 s at 100 MHz); legal range ≥ 1
- ACTIVE_LOW, 0, 1 = raw pin reads 0 when pressed; inverted before synchronization
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- btn_raw  input  1  raw, asynchronous button pin
- btn_level  output  1  debounced pressed level, 1 = pressed
- press  output  1  one-cycle pulse on accepted press
- release  output  1  one-cycle pulse on accepted release
- long_press  output  1  one-cycle pulse when a press has been held LONG_CYCLES
- press_count  output  8  count of accepted presses, wraps 255→0

## Operation
- Two-flop synchronizer on btn_raw, after optional polarity inversion; all later logic sees only the synchronized value s.
- 32-bit stability counter cnt counts consecutive cycles in which s differs from the committed level; any cycle with s equal to the committed level clears cnt.
- FSM states: IDLE (released), PRESS_CHK, HELD, LONG_HELD, RELEASE_CHK.
- IDLE: s=1 → PRESS_CHK.
- PRESS_CHK: s=0 → IDLE with cnt cleared. s=1 and cnt=DEBOUNCE_CYCLES-1 → HELD; that edge sets btn_level and pulses press; press_count increments; hold counter and long_flag clear.
- HELD: hold counter increments each cycle. At LONG_CYCLES-1 → LONG_HELD with a long_press pulse and long_flag set. s=0 → RELEASE_CHK.
- LONG_HELD: no further long_press pulses. s=0 → RELEASE_CHK.
- RELEASE_CHK: s=1 → back to HELD if long_flag=0, otherwise LONG_HELD. The hold counter pauses and does not reset. s=0 and cnt=DEBOUNCE_CYCLES-1 → IDLE; that edge clears btn_level and pulses release.
- press, release and long_press are mutually exclusive in any cycle. The long_press transition in HELD takes priority over entering RELEASE_CHK in the same cycle.
- press_count is 8-bit modulo; increments only on press.

## Timing
- Reset values:
  - btn_level=0, press=0, release=0, long_press=0, press_count=0
  - FSM=IDLE, cnt=0, hold counter=0, synchronizer flops=0 (post-inversion)
- Reset mid-operation returns to IDLE immediately. No release pulse is emitted; press_count clears.
- Latency from a clean raw transition to btn_level change: 2 + DEBOUNCE_CYCLES clock cycles. The pulse asserts in the same cycle that btn_level changes.
- long_press asserts LONG_CYCLES cycles after press asserts, provided no release-check excursion occurred; excursion cycles are not counted.
- All outputs are registered; no combinational path from btn_raw.
- DEBOUNCE_CYCLES=1: a new level is accepted on the first synchronized cycle.

## Configuration
- Macro LONG_PRESS_EN.
- Defined: hold counter, long_flag, LONG_HELD state and long_press behave as above.
- Undefined: LONG_HELD, hold counter and long_flag are not built; long_press is tied to 0; RELEASE_CHK always returns to HELD. LONG_CYCLES is ignored.

## Structure
- Shared package btn_pkg:
  - FSM state enum
  - counter width constant CNT_W=32
  - PRESS_CNT_W=8
  - default cycle constants for a 100 MHz clock (10 ms, 1 s)
- One sub-module: sync_2ff, a reusable two-flop synchronizer with async active-low reset and a parameterized reset value, also usable for other board inputs.

## Test plan
- Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
- Clean press: btn_raw 0→1 held → btn_level=1 and press pulse exactly 6 cycles after the edge; press_count=1.
- Bounce: btn_raw toggles 1,0,1,0 with 2-cycle periods, then stable 1 → no pulses during bounce; press 6 cycles after the final rising edge; press_count=1.
- Long press: hold 1 for 40 cycles → press at 6; long_press one cycle at 26; release 6 cycles after the falling edge; no second long_press.
- Release glitch: while HELD, drop btn_raw for 2 cycles → no release; btn_level stays 1; hold count resumes.
- Wrap and reset: 256 clean presses → press_count=0. Assert rst_n low while pressed → all outputs 0 at once, no release pulse.
- ACTIVE_LOW=1: btn_raw 1→0 → press after 6 cycles; LONG_PRESS_EN undefined build → long_press stays 0 over a 40-cycle hold.
